// File: rtl/pulse_monitor_pkg.sv
// Shared types and default constants for the pulse monitor.
//   state_e      : monitor FSM states
//   *_DEF        : default PERIOD / CBITS / LOCK_CNT parameter values
//   sat_inc8     : 8-bit saturating increment used by the fault counter
package pulse_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int unsigned PERIOD_DEF   = 22501;
  localparam int unsigned CBITS_DEF    = 15;
  localparam int unsigned LOCK_CNT_DEF = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pulse_gap_counter.sv
// Gap counter between pulse events.
//   clk, rst   : clock, async active-high reset
//   clear      : re-anchor (cnt -> 0) on a pulse event, else increment/saturate
//   gap_short  : measured gap (cnt+1) would be below PERIOD
//   gap_exact  : measured gap (cnt+1) equals PERIOD
//   at_period  : cnt == PERIOD (pulse is overdue)
module pulse_gap_counter
  import pulse_monitor_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_DEF,
  parameter int unsigned CBITS  = CBITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic gap_short,
  output logic gap_exact,
  output logic at_period
);

  localparam logic [CBITS-1:0] PER_C   = CBITS'(PERIOD);
  localparam logic [CBITS-1:0] PERM1_C = CBITS'(PERIOD - 1);
  localparam logic [CBITS-1:0] ONE_C   = CBITS'(1);
  localparam logic [CBITS-1:0] MAX_C   = '1;

  logic [CBITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)               cnt_d = '0;
    else if (cnt_q != MAX_C) cnt_d = cnt_q + ONE_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign gap_short = (cnt_q < PERM1_C);
  assign gap_exact = (cnt_q == PERM1_C);
  assign at_period = (cnt_q == PER_C);

endmodule

// File: rtl/pulse_monitor.sv
// Periodic pulse monitor: locks onto a pulse stream of period PERIOD and
// flags early, late and over-wide pulses.
//   clk, rst  : clock, async active-high reset
//   sig       : monitored pulse stream (nominally one cycle high)
//   clr       : synchronous clear of err and fault_cnt
//   locked    : high while locked onto the stream
//   err       : sticky, any fault seen while locked
//   early     : one-cycle, pulse before PERIOD
//   late      : one-cycle, pulse missing at PERIOD
//   wide      : one-cycle, sig high on two consecutive edges
//   fault_cnt : saturating count of edges carrying early/late/wide
module pulse_monitor
  import pulse_monitor_pkg::*;
#(
  parameter int unsigned PERIOD   = PERIOD_DEF,
  parameter int unsigned CBITS    = CBITS_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic       clr,
  output logic       locked,
  output logic       err,
  output logic       early,
  output logic       late,
  output logic       wide,
  output logic [7:0] fault_cnt
);

  localparam int unsigned     GBITS  = $clog2(LOCK_CNT + 1);
  localparam logic [GBITS-1:0] LOCK_C = GBITS'(LOCK_CNT);
  localparam logic [GBITS-1:0] GONE_C = GBITS'(1);

  state_e           state_q, state_d;
  logic [GBITS-1:0] good_q, good_d;
  logic             sig_q;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic             wide_q, wide_d;
  logic [7:0]       fault_q, fault_d;

  logic pulse_ev, wide_ev, any_ev;
  logic gap_short, gap_exact, at_period;

  assign pulse_ev = sig & ~sig_q;
  assign wide_ev  = sig & sig_q;

  pulse_gap_counter #(
    .PERIOD(PERIOD),
    .CBITS (CBITS)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .clear    (pulse_ev),
    .gap_short(gap_short),
    .gap_exact(gap_exact),
    .at_period(at_period)
  );

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    early_d = 1'b0;
    late_d  = 1'b0;
    wide_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pulse_ev) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE, ST_LOCKED: begin
        if (pulse_ev) begin
          if (gap_short) begin
            early_d = 1'b1;
            good_d  = '0;
            state_d = ST_ACQUIRE;
          end else if (gap_exact) begin
            good_d = (good_q == LOCK_C) ? good_q : good_q + GONE_C;
            if (good_d == LOCK_C) state_d = ST_LOCKED;
          end else begin
            // Gap of PERIOD+1: overdue, but the pulse still serves as a fresh anchor.
            late_d  = 1'b1;
            good_d  = '0;
            state_d = ST_ACQUIRE;
          end
        end else if (at_period) begin
          late_d  = 1'b1;
          good_d  = '0;
          state_d = ST_IDLE;
        end
        if (wide_ev) begin
          wide_d = 1'b1;
          good_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        good_d  = '0;
      end
    endcase
  end

  assign any_ev   = early_d | late_d | wide_d;
  assign locked_d = (state_d == ST_LOCKED);

  // Clear first, then let a same-edge event override it.
  always_comb begin
    err_d   = err_q;
    fault_d = fault_q;
    if (clr) begin
      err_d   = 1'b0;
      fault_d = '0;
    end
    if (any_ev) fault_d = sat_inc8(fault_d);
    if (any_ev && (state_q == ST_LOCKED)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      good_q   <= '0;
      sig_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      wide_q   <= 1'b0;
      fault_q  <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      sig_q    <= sig;
      locked_q <= locked_d;
      err_q    <= err_d;
      early_q  <= early_d;
      late_q   <= late_d;
      wide_q   <= wide_d;
      fault_q  <= fault_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign early     = early_q;
  assign late      = late_q;
  assign wide      = wide_q;
  assign fault_cnt = fault_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed bench for pulse_monitor with PERIOD=5, CBITS=4, LOCK_CNT=3.
module tb_pulse_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig;
  logic       clr;
  logic       locked, err, early, late, wide;
  logic [7:0] fault_cnt;

  int unsigned ncmp  = 0;
  int unsigned nfail = 0;

  pulse_monitor #(
    .PERIOD  (5),
    .CBITS   (4),
    .LOCK_CNT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig      (sig),
    .clr      (clr),
    .locked   (locked),
    .err      (err),
    .early    (early),
    .late     (late),
    .wide     (wide),
    .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge with sig driven to s; returns 1 time unit after the edge.
  task automatic step(input logic s);
    sig = s;
    @(posedge clk);
    #1;
  endtask

  // n-1 low edges followed by a high edge: next pulse at gap n.
  task automatic gp(input int unsigned n);
    for (int unsigned i = 1; i < n; i++) step(1'b0);
    step(1'b1);
  endtask

  task automatic chk_flags(input string tag, input logic l, input logic e,
                           input logic ea, input logic la, input logic w,
                           input logic [7:0] f);
    chk({tag, ".locked"}, {31'd0, locked}, {31'd0, l});
    chk({tag, ".err"},    {31'd0, err},    {31'd0, e});
    chk({tag, ".early"},  {31'd0, early},  {31'd0, ea});
    chk({tag, ".late"},   {31'd0, late},   {31'd0, la});
    chk({tag, ".wide"},   {31'd0, wide},   {31'd0, w});
    chk({tag, ".fault"},  {24'd0, fault_cnt}, {24'd0, f});
  endtask

  initial begin
    rst = 1'b1; sig = 1'b0; clr = 1'b0;
    #2;
    chk_flags("reset_async", 0, 0, 0, 0, 0, 8'd0);
    step(1'b0);
    step(1'b0);
    chk_flags("reset_held", 0, 0, 0, 0, 0, 8'd0);
    rst = 1'b0;

    // Lock acquisition: anchor + three good gaps.
    step(1'b1);
    chk_flags("anchor", 0, 0, 0, 0, 0, 8'd0);
    gp(5);
    gp(5);
    chk_flags("acq_good2", 0, 0, 0, 0, 0, 8'd0);
    gp(5);
    chk_flags("lock1", 1, 0, 0, 0, 0, 8'd0);

    // Early pulse while locked.
    gp(3);
    chk_flags("early_hit", 0, 1, 1, 0, 0, 8'd1);
    step(1'b0);
    chk_flags("early_gone", 0, 1, 0, 0, 0, 8'd1);
    gp(4);
    gp(5);
    chk_flags("relock_good2", 0, 1, 0, 0, 0, 8'd1);
    gp(5);
    chk_flags("relock", 1, 1, 0, 0, 0, 8'd1);

    // Clear with no event.
    clr = 1'b1;
    step(1'b0);
    clr = 1'b0;
    chk_flags("clr_locked", 1, 0, 0, 0, 0, 8'd0);
    gp(4);
    chk_flags("still_locked", 1, 0, 0, 0, 0, 8'd0);

    // Withheld pulse: late on the edge that sees cnt=5.
    for (int i = 0; i < 5; i++) step(1'b0);
    chk_flags("late_pre", 1, 0, 0, 0, 0, 8'd0);
    step(1'b0);
    chk_flags("late_hit", 0, 1, 0, 1, 0, 8'd1);
    step(1'b0);
    chk_flags("late_gone", 0, 1, 0, 0, 0, 8'd1);
    clr = 1'b1;
    step(1'b0);
    clr = 1'b0;
    chk_flags("clr_idle", 0, 0, 0, 0, 0, 8'd0);
    step(1'b1);
    chk_flags("idle_anchor", 0, 0, 0, 0, 0, 8'd0);
    gp(5);
    gp(5);
    chk_flags("post_late_good2", 0, 0, 0, 0, 0, 8'd0);
    gp(5);
    chk_flags("post_late_lock", 1, 0, 0, 0, 0, 8'd0);

    // Reset asserted between edges while locked.
    rst = 1'b1;
    #2;
    chk_flags("rst_mid", 0, 0, 0, 0, 0, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Wide pulse in ACQUIRE; first edge after release is an anchor.
    step(1'b1);
    chk_flags("rst_anchor", 0, 0, 0, 0, 0, 8'd0);
    gp(5);
    step(1'b1);
    chk_flags("wide_hit", 0, 0, 0, 0, 1, 8'd1);
    step(1'b0);
    chk_flags("wide_gone", 0, 0, 0, 0, 0, 8'd1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    gp(5);
    chk_flags("wide_good2", 0, 0, 0, 0, 0, 8'd1);
    gp(5);
    chk_flags("wide_relock", 1, 0, 0, 0, 0, 8'd1);

    // 300 early pulses: first one while locked sets err.
    for (int i = 0; i < 300; i++) begin
      step(1'b0);
      step(1'b1);
      if (i == 99) chk_flags("early_100", 0, 1, 1, 0, 0, 8'd101);
    end
    chk_flags("fault_sat", 0, 1, 1, 0, 0, 8'd255);
    clr = 1'b1;
    step(1'b0);
    clr = 1'b0;
    chk_flags("clr_sat", 0, 0, 0, 0, 0, 8'd0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    chk_flags("fault_two", 0, 0, 1, 0, 0, 8'd2);
    step(1'b0);
    clr = 1'b1;
    step(1'b1);
    clr = 1'b0;
    chk_flags("clr_vs_event", 0, 0, 1, 0, 0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
